trail_store: RTL and testbench

Trail-grid storage for the light-cycle playfield: consumes the per-frame trail codes for Blue and Red and their grid positions, writes them into a 112x112 grid of 3-bit cells, and checks each head's target cell for collisions before writing. It sits between the trail-code generator (which produces `write_b`/`write_r`) and the renderer, which reads cells through a second read port. The grid is cleared on reset release and on every entry to the start state.

---
 rtl/trail_pkg.sv | 34 +++
 rtl/trail_ram.sv | 29 ++
 rtl/trail_store.sv | 183 ++++++++++++++++++
 tb/tb_trail_store.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared constants, codes and FSM states for the trail-grid store.
package trail_pkg;

    localparam int GRID_W     = 112;
    localparam int GRID_H     = 112;
    localparam int GRID_CELLS = GRID_W * GRID_H;

    localparam logic [2:0] GS_START = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;

    typedef enum logic [2:0] {
        TC_NONE    = 3'd0,
        TC_B_HORIZ = 3'd1,
        TC_B_VERT  = 3'd2,
        TC_R_HORIZ = 3'd3,
        TC_R_VERT  = 3'd4,
        TC_CORNER  = 3'd5
    } trail_code_e;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CHK_B,
        S_CHK_R,
        S_CMP,
        S_WR_B,
        S_WR_R
    } trail_state_e;

    function automatic logic [13:0] cell_addr(input logic [6:0] x, input logic [6:0] y);
        return 14'(y) * 14'(GRID_W) + 14'(x);
    endfunction

endpackage

// File: rtl/trail_ram.sv
// 12544x3 dual-port grid RAM: port A write plus registered read, port B registered read.
module trail_ram
    import trail_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [13:0] i_addr_a,
    input  logic [2:0]  i_wd,
    input  logic [13:0] i_addr_b,
    output logic [2:0]  o_rd_a,
    output logic [2:0]  o_rd_b
);

    logic [2:0] r_mem [GRID_CELLS];
    logic [2:0] r_rd_a;
    logic [2:0] r_rd_b;

    // No reset on the array; out-of-range addresses read as empty.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_addr_a < 14'(GRID_CELLS)))
            r_mem[i_addr_a] <= i_wd;
        r_rd_a <= (i_addr_a < 14'(GRID_CELLS)) ? r_mem[i_addr_a] : 3'd0;
        r_rd_b <= (i_addr_b < 14'(GRID_CELLS)) ? r_mem[i_addr_b] : 3'd0;
    end

    assign o_rd_a = r_rd_a;
    assign o_rd_b = r_rd_b;

endmodule

// File: rtl/trail_store.sv
// Light-cycle trail grid: clear sweep, per-frame head checks and trail writes.
// Collision checking is built only when TRAIL_COLLISION_EN is defined.
// CLEAR: zero sweep | IDLE: wait tick | CHK_B/CHK_R: read heads | CMP: collide | WR_B/WR_R: write
module trail_store
    import trail_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] Game_State,
    input  logic [6:0] Blue_X,
    input  logic [6:0] Blue_Y,
    input  logic [6:0] Red_X,
    input  logic [6:0] Red_Y,
    input  logic [2:0] write_b,
    input  logic [2:0] write_r,
    input  logic [6:0] Read_X,
    input  logic [6:0] Read_Y,
    output logic [2:0] trail_code,
    output logic       collision_blue,
    output logic       collision_red,
    output logic       clear_busy
);

    localparam logic [6:0]  W7       = 7'(GRID_W);
    localparam logic [6:0]  H7       = 7'(GRID_H);
    localparam logic [13:0] LAST_CLR = 14'(GRID_CELLS - 1);

    trail_state_e r_state;
    logic [13:0]  r_clr_addr;
    logic         r_fc_meta, r_fc_sync, r_fc_prev;
    logic [2:0]   r_gs_prev;
    logic         r_rd_zero;

    logic [13:0]  w_addr_a;
    logic         w_we;
    logic [2:0]   w_wd;
    logic [2:0]   w_rd_b;
    logic [13:0]  w_addr_blue, w_addr_red;
    logic         w_oob_b, w_oob_r, w_rd_oob;
    logic         w_tick, w_start_rise;
    logic         w_wr_b_ok, w_wr_r_ok;

    assign w_addr_blue  = cell_addr(Blue_X, Blue_Y);
    assign w_addr_red   = cell_addr(Red_X, Red_Y);
    assign w_oob_b      = (Blue_X >= W7) || (Blue_Y >= H7);
    assign w_oob_r      = (Red_X >= W7) || (Red_Y >= H7);
    assign w_rd_oob     = (Read_X >= W7) || (Read_Y >= H7);
    assign w_tick       = r_fc_sync && !r_fc_prev;
    assign w_start_rise = (Game_State == GS_START) && (r_gs_prev != GS_START);

`ifdef TRAIL_COLLISION_EN
    logic [2:0] w_rd_a;
    logic [2:0] r_cell_b;
    logic       r_hit_b, r_hit_r;
    logic       r_col_b, r_col_r;
    logic       w_same, w_hit_b, w_hit_r;

    assign w_same = (Blue_X == Red_X) && (Blue_Y == Red_Y) &&
                    (write_b != TC_NONE) && (write_r != TC_NONE);
    assign w_hit_b = (r_cell_b != TC_NONE) || w_oob_b || w_same;
    assign w_hit_r = (w_rd_a != TC_NONE) || w_oob_r || w_same;
    assign w_wr_b_ok = (write_b != TC_NONE) && !w_oob_b && !r_hit_b;
    assign w_wr_r_ok = (write_r != TC_NONE) && !w_oob_r && !r_hit_r;
    assign collision_blue = r_col_b;
    assign collision_red  = r_col_r;
`else
    logic [2:0] w_unused_rd_a;

    assign w_wr_b_ok = (write_b != TC_NONE) && !w_oob_b;
    assign w_wr_r_ok = (write_r != TC_NONE) && !w_oob_r;
    assign collision_blue = 1'b0;
    assign collision_red  = 1'b0;
`endif

    always_comb begin
        w_addr_a = r_clr_addr;
        w_we     = 1'b0;
        w_wd     = 3'd0;
        case (r_state)
            S_CLEAR: w_we = 1'b1;
            S_CHK_B: w_addr_a = w_addr_blue;
            S_CHK_R: w_addr_a = w_addr_red;
            S_WR_B: begin
                w_addr_a = w_addr_blue;
                w_we     = w_wr_b_ok;
                w_wd     = write_b;
            end
            S_WR_R: begin
                w_addr_a = w_addr_red;
                w_we     = w_wr_r_ok;
                w_wd     = write_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_fc_meta  <= 1'b0;
            r_fc_sync  <= 1'b0;
            r_fc_prev  <= 1'b0;
            r_gs_prev  <= 3'd0;
            r_rd_zero  <= 1'b1;
`ifdef TRAIL_COLLISION_EN
            r_cell_b   <= 3'd0;
            r_hit_b    <= 1'b0;
            r_hit_r    <= 1'b0;
            r_col_b    <= 1'b0;
            r_col_r    <= 1'b0;
`endif
        end else begin
            r_fc_meta <= frame_clk;
            r_fc_sync <= r_fc_meta;
            r_fc_prev <= r_fc_sync;
            r_gs_prev <= Game_State;
            r_rd_zero <= w_rd_oob || (r_state == S_CLEAR);
            // A start request abandons any in-flight sequence, but never restarts a running sweep.
            if (w_start_rise && (r_state != S_CLEAR)) begin
                r_state    <= S_CLEAR;
                r_clr_addr <= '0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
`ifdef TRAIL_COLLISION_EN
                        r_col_b <= 1'b0;
                        r_col_r <= 1'b0;
`endif
                        if (r_clr_addr == LAST_CLR)
                            r_state <= S_IDLE;
                        else
                            r_clr_addr <= r_clr_addr + 14'd1;
                    end
                    S_IDLE: begin
                        if (w_tick && (Game_State == GS_PLAY))
`ifdef TRAIL_COLLISION_EN
                            r_state <= S_CHK_B;
`else
                            r_state <= S_WR_B;
`endif
                    end
`ifdef TRAIL_COLLISION_EN
                    S_CHK_B: r_state <= S_CHK_R;
                    S_CHK_R: begin
                        r_cell_b <= w_rd_a;
                        r_state  <= S_CMP;
                    end
                    S_CMP: begin
                        r_hit_b <= w_hit_b;
                        r_hit_r <= w_hit_r;
                        r_col_b <= r_col_b | w_hit_b;
                        r_col_r <= r_col_r | w_hit_r;
                        r_state <= S_WR_B;
                    end
`endif
                    S_WR_B:  r_state <= S_WR_R;
                    S_WR_R:  r_state <= S_IDLE;
                    default: r_state <= S_CLEAR;
                endcase
            end
        end
    end

    trail_ram u_ram (
        .i_clk    (Clk),
        .i_we     (w_we),
        .i_addr_a (w_addr_a),
        .i_wd     (w_wd),
        .i_addr_b (cell_addr(Read_X, Read_Y)),
`ifdef TRAIL_COLLISION_EN
        .o_rd_a   (w_rd_a),
`else
        .o_rd_a   (w_unused_rd_a),
`endif
        .o_rd_b   (w_rd_b)
    );

    assign trail_code = r_rd_zero ? 3'd0 : w_rd_b;
    assign clear_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_trail_store.sv
// Directed bench for trail_store with a grid-level reference model; honours TRAIL_COLLISION_EN.
module tb_trail_store;

    localparam int GW = 112;
    localparam int GH = 112;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] Game_State;
    logic [6:0] Blue_X, Blue_Y, Red_X, Red_Y;
    logic [2:0] write_b, write_r;
    logic [6:0] Read_X, Read_Y;
    logic [2:0] trail_code;
    logic       collision_blue, collision_red, clear_busy;

    int checks = 0;
    int errors = 0;

    int m_grid[GW*GH];
    bit m_col_b, m_col_r;

    bit         chk_en = 1'b0;
    bit         lat_en = 1'b0;
    logic [6:0] lat_x, lat_y;
    int         exp_code;

`ifdef TRAIL_COLLISION_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif

    int sx[13] = '{0, 111, 10, 11, 60, 50, 30, 0, 5, 6, 112, 3, 111};
    int sy[13] = '{0, 111, 20, 20, 70, 50, 40, 6, 5, 6, 0, 127, 0};

    trail_store dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .Game_State     (Game_State),
        .Blue_X         (Blue_X),
        .Blue_Y         (Blue_Y),
        .Red_X          (Red_X),
        .Red_Y          (Red_Y),
        .write_b        (write_b),
        .write_r        (write_r),
        .Read_X         (Read_X),
        .Read_Y         (Read_Y),
        .trail_code     (trail_code),
        .collision_blue (collision_blue),
        .collision_red  (collision_red),
        .clear_busy     (clear_busy)
    );

    always #10 Clk = ~Clk;

    function automatic int model_read(int x, int y);
        if (x >= GW || y >= GH) return 0;
        return m_grid[y*GW + x];
    endfunction

    task automatic model_clear();
        foreach (m_grid[i]) m_grid[i] = 0;
        m_col_b = 1'b0;
        m_col_r = 1'b0;
    endtask

    task automatic model_tick(int bx, int by, int rx, int ry, int wb, int wr);
        bit oob_b, oob_r, same, hb, hr;
        oob_b = (bx >= GW) || (by >= GH);
        oob_r = (rx >= GW) || (ry >= GH);
        same  = (bx == rx) && (by == ry) && (wb != 0) && (wr != 0);
        hb = 1'b0;
        hr = 1'b0;
        if (COL_EN) begin
            hb = (model_read(bx, by) != 0) || oob_b || same;
            hr = (model_read(rx, ry) != 0) || oob_r || same;
        end
        m_col_b = m_col_b | hb;
        m_col_r = m_col_r | hr;
        if (wb != 0 && !oob_b && !hb) m_grid[by*GW + bx] = wb;
        if (wr != 0 && !oob_r && !hr) m_grid[ry*GW + rx] = wr;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        lat_x  = Read_X;
        lat_y  = Read_Y;
        lat_en = chk_en;
    end

    always @(negedge Clk) begin
        if (lat_en) begin
            exp_code = model_read(int'(lat_x), int'(lat_y));
            checks++;
            if (trail_code !== 3'(exp_code) || collision_blue !== m_col_b ||
                collision_red !== m_col_r || clear_busy !== 1'b0) begin
                errors++;
                $display("FAIL cmp at (%0d,%0d): code %0d col_b %0b col_r %0b busy %0b, expected code %0d col_b %0b col_r %0b busy 0",
                         lat_x, lat_y, trail_code, collision_blue, collision_red, clear_busy,
                         exp_code, m_col_b, m_col_r);
            end
        end
    end

    task automatic read_cell(int x, int y, output int v);
        @(posedge Clk); #1;
        Read_X = 7'(x);
        Read_Y = 7'(y);
        @(posedge Clk);
        @(negedge Clk);
        v = int'(trail_code);
    endtask

    task automatic sweep_list();
        @(posedge Clk); #1;
        chk_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            Read_X = 7'(sx[i]);
            Read_Y = 7'(sy[i]);
            @(posedge Clk); #1;
        end
        chk_en = 1'b0;
    endtask

    task automatic sweep_full();
        @(posedge Clk); #1;
        chk_en = 1'b1;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                Read_X = 7'(x);
                Read_Y = 7'(y);
                @(posedge Clk); #1;
            end
        end
        chk_en = 1'b0;
    endtask

    task automatic do_tick(int bx, int by, int rx, int ry, int wb, int wr);
        @(posedge Clk); #1;
        Game_State = 3'b010;
        Blue_X = 7'(bx); Blue_Y = 7'(by);
        Red_X  = 7'(rx); Red_Y  = 7'(ry);
        write_b = 3'(wb); write_r = 3'(wr);
        frame_clk = 1'b1;
        repeat (12) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        model_tick(bx, by, rx, ry, wb, wr);
    endtask

    task automatic wait_clear_done();
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < 13000) begin
            @(negedge Clk);
            n++;
        end
        if (clear_busy !== 1'b0) check("clear_timeout", 1, 0);
        repeat (3) @(posedge Clk);
    endtask

    task automatic start_clear(int rx, int ry);
        int v;
        @(posedge Clk); #1;
        Game_State = 3'b001;
        repeat (2) @(posedge Clk);
        read_cell(rx, ry, v);
        check("read_during_clear", v, 0);
        check("busy_during_clear", int'(clear_busy), 1);
        @(posedge Clk); #1;
        Game_State = 3'b010;
        Blue_X = 7'd5; Blue_Y = 7'd5; write_b = 3'd1;
        Red_X  = 7'd6; Red_Y  = 7'd6; write_r = 3'd1;
        frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 frame_clk = 1'b0;
        wait_clear_done();
        model_clear();
    endtask

    initial begin
        int v, cnt;
        Reset = 1'b0;
        frame_clk = 1'b0;
        Game_State = 3'b000;
        Blue_X = '0; Blue_Y = '0; Red_X = '0; Red_Y = '0;
        write_b = '0; write_r = '0;
        Read_X = '0; Read_Y = '0;
        model_clear();

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_clear_busy", int'(clear_busy), 1);
        check("rst_col_blue", int'(collision_blue), 0);
        check("rst_col_red", int'(collision_red), 0);
        check("rst_trail_code", int'(trail_code), 0);

        @(posedge Clk); #1 Reset = 1'b1;
        cnt = 0;
        forever begin
            @(negedge Clk);
            if (clear_busy !== 1'b1 || cnt >= 20000) break;
            cnt++;
        end
        check("clear_len", cnt, 12544);
        repeat (2) @(posedge Clk);

        sweep_list();
        read_cell(0, 0, v);     check("empty_0_0", v, 0);
        read_cell(111, 111, v); check("empty_111_111", v, 0);

        do_tick(10, 20, 0, 0, 1, 0);
        read_cell(10, 20, v);   check("cell_2250_first", v, 1);
        check("col_blue_first", int'(collision_blue), 0);
        sweep_list();

        do_tick(11, 20, 60, 70, 5, 4);
        read_cell(60, 70, v);   check("red_cell_60_70", v, 4);
        sweep_list();

        do_tick(10, 20, 0, 0, 2, 0);
        read_cell(10, 20, v);   check("cell_2250_second", v, COL_EN ? 1 : 2);
        check("col_blue_occupied", int'(collision_blue), COL_EN ? 1 : 0);
        sweep_list();

        start_clear(10, 20);
        check("flags_after_clear_b", int'(collision_blue), 0);
        check("flags_after_clear_r", int'(collision_red), 0);
        read_cell(5, 5, v);     check("dropped_tick_cell", v, 0);
        sweep_list();

        do_tick(112, 5, 30, 40, 1, 4);
        check("col_blue_oob", int'(collision_blue), COL_EN ? 1 : 0);
        check("col_red_oob_side", int'(collision_red), 0);
        read_cell(30, 40, v);   check("red_write_oob_case", v, 4);
        read_cell(0, 6, v);     check("no_wrap_write", v, 0);
        sweep_list();

        do_tick(50, 50, 50, 50, 1, 3);
        check("col_red_shared", int'(collision_red), COL_EN ? 1 : 0);
        read_cell(50, 50, v);   check("cell_5650_shared", v, COL_EN ? 0 : 3);
        sweep_list();

        start_clear(30, 40);
        sweep_full();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
